fft_reorder_ctrl: RTL and testbench
===================================

# fft_reorder_ctrl

Ping-pong reorder controller for the FFT output path. It owns two single-port reorder SRAM banks. Each bank holds one frame of N = 2^ADDR_WIDTH samples, written in natural order and read back in bit-reversed or natural order. The two banks alternate, so one frame fills while the previous frame drains. The block sits between the last butterfly stage and the downstream consumer, with valid/ready on both sides.

## Interface
- ADDR_WIDTH, 8, log2 of frame length N; also the bank address width
- DATA_WIDTH, 32, sample width (packed complex {re, im})

- clk  in  1  clock, posedge
- rst  in  1  reset, synchronous, active-high
- cfg_bitrev  in  1  1 = bit-reversed read order, 0 = natural; sampled per frame
- in_valid  in  1  input sample valid
- in_ready  out  1  controller can accept a sample
- in_data  in  DATA_WIDTH  input sample, natural order
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts the sample
- out_data  out  DATA_WIDTH  output sample
- out_last  out  1  marks sample N-1 of the output frame
- frame_done  out  1  single-cycle pulse when an output frame's last sample handshakes

## Operation
- Each bank has its own state: EMPTY, FILLING, FULL or DRAINING.
  - It also has a `bitrev` flag, latched from cfg_bitrev on the first write of a frame.
  - cfg_bitrev changes inside a frame are ignored.
- Write side: wr_bank pointer (0/1) and wr_cnt (ADDR_WIDTH bits).
  - in_ready = !rst && (bank[wr_bank] is EMPTY or FILLING).
  - On an input handshake: write in_data to bank[wr_bank] at address wr_cnt, then increment wr_cnt. The first write moves the bank EMPTY→FILLING.
  - At wr_cnt = N-1, the write marks the bank FULL, wr_cnt wraps to 0 and wr_bank toggles.
- Read side: rd_bank pointer and rd_cnt.
  - A read is issued when bank[rd_bank] is FULL or DRAINING and (!out_valid || out_ready).
  - Read address = bitrev(rd_cnt) if the bank's `bitrev` flag is 1, otherwise rd_cnt.
  - The first read moves the bank FULL→DRAINING.
  - The read with rd_cnt = N-1 moves the bank to EMPTY on that same edge, wraps rd_cnt and toggles rd_bank.
- Port conflict: a bank is never read and written in the same cycle. Ping-pong state guarantees this; an assertion checks it.
- out_data is the dout of the bank selected by a registered copy of the last-read bank. No extra data register is used.
  - dout holds when no read is issued, so out_data is stable during a stall.
  - Writes to that bank do not disturb its dout.
- out_valid is registered:
  - set on the edge after a read is issued;
  - cleared on an output handshake with no new read;
  - unchanged otherwise.
- out_last is registered: 1 when the issued read had rd_cnt = N-1.
- Reset: all banks EMPTY, wr/rd pointers and counters 0, out_valid = 0, out_last = 0, frame_done = 0, in_ready = 0 while rst is high and 1 after reset.
  - Reset may occur mid-fill or mid-drain. Any partial frame is discarded and SRAM contents are not cleared.
  - out_data after reset is don't-care.

## Timing
- Write: the sample is in the SRAM on the edge ending its handshake cycle.
- Read: 1-cycle SRAM latency. out_valid rises 1 cycle after read issue.
- Last input handshake in cycle t:
  - bank FULL at t+1;
  - first read issued in t+1;
  - out_valid high in t+2, provided that bank is the current rd_bank.
- Sustained throughput is 1 sample/cycle on both sides with continuous in_valid and out_ready=1.
- A bank released by its last read in cycle t is writable in cycle t+1. There is no bubble between back-to-back frames.
- Both banks FULL or DRAINING with the write bank busy: in_ready = 0 until a release.
- frame_done is asserted in the cycle of the out_last handshake.

## Structure
- Shared package fft_pkg holds:
  - a bank-state enum (EMPTY, FILLING, FULL, DRAINING);
  - a bitrev function parameterized by width.
- Sub-module: fft_reorder_sram, two instances, one per bank.
  - Single-port memory, 2^ADDR_WIDTH × DATA_WIDTH.
  - Ports ce/we/addr/din/dout, registered dout, dout held when not reading.
- The controller drives each bank's ce/we/addr/din, muxed between the write side and the read side by bank state.

## Test plan
- ADDR_WIDTH=3, cfg_bitrev=1, inputs 0..7 back-to-back, out_ready=1 → outputs 0,4,2,6,1,5,3,7; out_last and frame_done on 7; out_valid rises 2 cycles after the input-7 handshake.
- Same stimulus with cfg_bitrev=0 → outputs 0..7 in order.
- Three frames (0..23) streamed continuously, out_ready=1 → in_ready never drops after reset; outputs appear as frame-wise bit-reversed sequences with 1 sample/cycle and no gaps.
- out_ready held 0 during frames 1–2 → out_data/out_valid stay stable; in_ready drops after 16 accepted samples. Releasing out_ready → all 16 samples come out in correct order, and input resumes on the first released bank.
- rst pulsed in the middle of draining frame 1 → out_valid = 0 and in_ready = 1 the next cycle; a following frame 8..15 outputs 8,12,10,14,9,13,11,15.
- cfg_bitrev toggled mid-frame → order follows the value at the frame's first write; the bank-conflict assertion never fires in any test.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared types and helpers for the FFT output reorder path.
//                - bank_state_e : lifecycle of one ping-pong reorder bank
//                - bitrev()     : reverses the low 'width' bits of a value
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_e;

   // Widest address the reverse helper supports; callers zero-extend into it.
   localparam int BITREV_MAX_W = 16;
   localparam int BITREV_IDX_W = $clog2(BITREV_MAX_W);

   // Reverse bits [width-1:0] of value; bits at and above 'width' return 0.
   // With a constant width this reduces to pure wiring.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(
      input logic [BITREV_MAX_W-1:0] value,
      input int                      width
   );
      logic [BITREV_MAX_W-1:0] r;
      logic [BITREV_IDX_W-1:0] src;
      r = '0;
      for (int i = 0; i < BITREV_MAX_W; i++) begin
         src = BITREV_IDX_W'(width - 1 - i);
         if (i < width) r[i] = value[src];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder_sram.sv
`default_nettype none
// ============================================================================
//  Module      : fft_reorder_sram
//  Description : Single-port reorder bank, 2^ADDR_WIDTH x DATA_WIDTH.
//                Registered read data that holds its value whenever no read
//                is performed (idle cycles and write cycles alike).
//  Ports       : clk    - clock, posedge
//                ce_i   - access enable
//                we_i   - 1 = write, 0 = read (qualified by ce_i)
//                addr_i - word address
//                din_i  - write data
//                dout_o - read data, valid the cycle after a read
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_sram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  ce_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] dout_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] dout_q;

   // No reset: memory contents and read data survive a controller reset.
   always_ff @(posedge clk) begin
      if (ce_i) begin
         if (we_i) mem_q[addr_i] <= din_i;
         else      dout_q        <= mem_q[addr_i];
      end
   end

   assign dout_o = dout_q;

endmodule
`default_nettype wire

// File: rtl/fft_reorder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_reorder_ctrl
//  Description : Ping-pong reorder controller for the FFT output path. Two
//                single-port banks alternate: one fills in natural order
//                while the other drains in bit-reversed or natural order.
//  Ports       : clk, rst        - clock (posedge), synchronous active-high reset
//                cfg_bitrev_i    - read order for the next frame (1 = bit-reversed)
//                in_valid_i/in_ready_o/in_data_i     - input sample stream
//                out_valid_o/out_ready_i/out_data_o  - output sample stream
//                out_last_o      - last sample of an output frame
//                frame_done_o    - pulse on the handshake of the last sample
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_ctrl
   import fft_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,   // at most BITREV_MAX_W
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_bitrev_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_last_o,
   output logic                  frame_done_o
);

   localparam logic [ADDR_WIDTH-1:0] c_cnt_last = '1;
   localparam logic [ADDR_WIDTH-1:0] c_cnt_one  = ADDR_WIDTH'(1);

   bank_state_e           bank_state_q [2];
   bank_state_e           bank_state_d [2];
   logic [1:0]            bitrev_q, bitrev_d;
   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic                  out_bank_q, out_bank_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;

   logic                  w_wr_fire;
   logic                  w_rd_fire;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic [DATA_WIDTH-1:0] w_dout [2];

   always_comb begin
      in_ready_o = !rst && ((bank_state_q[wr_bank_q] == BANK_EMPTY) ||
                            (bank_state_q[wr_bank_q] == BANK_FILLING));
      w_wr_fire  = in_valid_i && in_ready_o;
      // A read may be issued whenever the output register is free or is
      // being emptied this cycle.
      w_rd_fire  = !rst && ((bank_state_q[rd_bank_q] == BANK_FULL) ||
                            (bank_state_q[rd_bank_q] == BANK_DRAINING)) &&
                   (!out_valid_q || out_ready_i);
      w_rd_addr  = bitrev_q[rd_bank_q]
                 ? ADDR_WIDTH'(bitrev(BITREV_MAX_W'(rd_cnt_q), ADDR_WIDTH))
                 : rd_cnt_q;
   end

   always_comb begin
      bank_state_d = bank_state_q;
      bitrev_d     = bitrev_q;
      wr_bank_d    = wr_bank_q;
      wr_cnt_d     = wr_cnt_q;
      rd_bank_d    = rd_bank_q;
      rd_cnt_d     = rd_cnt_q;
      out_bank_d   = out_bank_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;

      if (w_wr_fire) begin
         // Read order is frozen by the first write of the frame.
         if (bank_state_q[wr_bank_q] == BANK_EMPTY) bitrev_d[wr_bank_q] = cfg_bitrev_i;
         wr_cnt_d = wr_cnt_q + c_cnt_one;
         if (wr_cnt_q == c_cnt_last) begin
            bank_state_d[wr_bank_q] = BANK_FULL;
            wr_bank_d               = ~wr_bank_q;
         end else begin
            bank_state_d[wr_bank_q] = BANK_FILLING;
         end
      end

      if (w_rd_fire) begin
         rd_cnt_d    = rd_cnt_q + c_cnt_one;
         out_bank_d  = rd_bank_q;
         out_valid_d = 1'b1;
         out_last_d  = (rd_cnt_q == c_cnt_last);
         // Releasing the bank on the last read lets the writer reuse it
         // in the very next cycle.
         if (rd_cnt_q == c_cnt_last) begin
            bank_state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d               = ~rd_bank_q;
         end else begin
            bank_state_d[rd_bank_q] = BANK_DRAINING;
         end
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_state_q <= '{default: BANK_EMPTY};
         bitrev_q     <= '0;
         wr_bank_q    <= 1'b0;
         wr_cnt_q     <= '0;
         rd_bank_q    <= 1'b0;
         rd_cnt_q     <= '0;
         out_bank_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
      end else begin
         bank_state_q <= bank_state_d;
         bitrev_q     <= bitrev_d;
         wr_bank_q    <= wr_bank_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_bank_q    <= rd_bank_d;
         rd_cnt_q     <= rd_cnt_d;
         out_bank_q   <= out_bank_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
      end
   end

   // The writer only touches EMPTY/FILLING banks and the reader only
   // FULL/DRAINING ones, so one bank never sees both in a cycle.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(w_wr_fire && w_rd_fire && (wr_bank_q == rd_bank_q)));
   end

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         logic w_sel_wr;
         logic w_sel_rd;
         assign w_sel_wr = w_wr_fire && (wr_bank_q == 1'(b));
         assign w_sel_rd = w_rd_fire && (rd_bank_q == 1'(b));

         fft_reorder_sram #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
         ) u_sram (
            .clk    (clk),
            .ce_i   (w_sel_wr || w_sel_rd),
            .we_i   (w_sel_wr),
            .addr_i (w_sel_wr ? wr_cnt_q : w_rd_addr),
            .din_i  (in_data_i),
            .dout_o (w_dout[b])
         );
      end
   endgenerate

   // Output data comes straight from the bank that served the last read;
   // its dout holds during stalls, so no extra output register is needed.
   assign out_data_o   = w_dout[out_bank_q];
   assign out_valid_o  = out_valid_q;
   assign out_last_o   = out_last_q;
   assign frame_done_o = !rst && out_valid_q && out_ready_i && out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_reorder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_reorder_ctrl
//  Description : Scoreboard bench for fft_reorder_ctrl with 8-sample frames.
//                Expected output frames are queued when a frame is driven and
//                popped by a monitor on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_reorder_ctrl;

   localparam int AW = 3;
   localparam int DW = 32;
   localparam int N  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_bitrev = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          frame_done;

   fft_reorder_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_bitrev_i (cfg_bitrev),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .out_last_o   (out_last),
      .frame_done_o (frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   first_out_cyc = -1;
   int   last_out_cyc  = -1;
   int   out_count     = 0;
   int   hs_cyc        = 0;
   int   first_hs_cyc  = 0;
   int   br_tbl [N]    = '{0, 4, 2, 6, 1, 5, 3, 7};

   // Output monitor: every handshake is compared with the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output got %0d, none expected", out_data);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (out_data !== e.data) begin
               errors++;
               $display("FAIL out_data got %0d required %0d", out_data, e.data);
            end
            checks++;
            if (out_last !== e.last) begin
               errors++;
               $display("FAIL out_last data=%0d got %b required %b", e.data, out_last, e.last);
            end
            checks++;
            if (frame_done !== e.last) begin
               errors++;
               $display("FAIL frame_done data=%0d got %b required %b", e.data, frame_done, e.last);
            end
         end
         if (first_out_cyc < 0) first_out_cyc = cyc;
         last_out_cyc = cyc;
         out_count++;
      end else if (!rst && frame_done) begin
         checks++; errors++;
         $display("FAIL frame_done_no_handshake got 1 required 0");
      end
   end

   task automatic push_frame(input logic [DW-1:0] base, input bit br);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.data = base + (br ? br_tbl[i] : i);
         e.last = (i == N - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_sample(input logic [DW-1:0] d, input bit br, output int waited);
      bit ok;
      ok = 1'b0;
      waited = 0;
      in_valid = 1'b1;
      in_data = d;
      cfg_bitrev = br;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin ok = 1'b1; break; end
         waited++;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL in_accept_timeout data=%0d in_ready=%b required 1", d, in_ready);
      end else begin
         hs_cyc = cyc;
         @(posedge clk); #1;
      end
   endtask

   // Drives one frame; cfg_bitrev flips from sample toggle_at onwards.
   task automatic send_frame(input logic [DW-1:0] base, input bit br, input int toggle_at,
                             input bit keep_valid, output int stalls);
      int w;
      push_frame(base, br);
      stalls = 0;
      for (int i = 0; i < N; i++) begin
         drive_sample(base + i, (i >= toggle_at) ? !br : br, w);
         if (i == 0) first_hs_cyc = hs_cyc;
         stalls += w;
      end
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout pending got %0d required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_out_valid got %b required 0", out_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
      checks++;
      if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b required 0", out_last); end
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b required 0", frame_done); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b required 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_bitrev_order();
      int s, t;
      first_out_cyc = -1;
      send_frame(0, 1'b1, N, 1'b0, s);
      t = hs_cyc;
      wait_drain();
      checks++;
      if (first_out_cyc != t + 2) begin
         errors++;
         $display("FAIL first_out_latency got cycle %0d required %0d", first_out_cyc, t + 2);
      end
   endtask

   task automatic test_natural_order();
      int s;
      send_frame(0, 1'b0, N, 1'b0, s);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int s0, s1, s2;
      first_out_cyc = -1;
      out_count = 0;
      send_frame(0,  1'b1, N, 1'b1, s0);
      send_frame(8,  1'b1, N, 1'b1, s1);
      send_frame(16, 1'b1, N, 1'b0, s2);
      checks++;
      if (s0 + s1 + s2 != 0) begin
         errors++;
         $display("FAIL stream_in_ready_stalls got %0d required 0", s0 + s1 + s2);
      end
      wait_drain();
      checks++;
      if (out_count != 3 * N || last_out_cyc - first_out_cyc != 3 * N - 1) begin
         errors++;
         $display("FAIL stream_gapless got count=%0d span=%0d required count=%0d span=%0d",
                  out_count, last_out_cyc - first_out_cyc, 3 * N, 3 * N - 1);
      end
   endtask

   task automatic test_stall();
      int s;
      int rel;
      logic [DW-1:0] d0;
      logic [DW-1:0] exp0;
      out_ready = 1'b0;
      send_frame(100, 1'b1, N, 1'b0, s);
      send_frame(108, 1'b1, N, 1'b0, s);
      exp0 = exp_q[0].data;
      in_valid = 1'b1;
      in_data = 116;
      @(negedge clk);
      d0 = out_data;
      checks++;
      if (out_valid !== 1'b1 || d0 !== exp0) begin
         errors++;
         $display("FAIL stall_head got valid=%b data=%0d required valid=1 data=%0d", out_valid, d0, exp0);
      end
      repeat (6) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== d0) begin
         errors++;
         $display("FAIL stall_stable got valid=%b data=%0d required valid=1 data=%0d", out_valid, out_data, d0);
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b required 0", in_ready); end
      @(posedge clk); #1;
      out_ready = 1'b1;
      rel = cyc;
      send_frame(116, 1'b1, N, 1'b0, s);
      checks++;
      if (first_hs_cyc != rel + N - 1) begin
         errors++;
         $display("FAIL resume_cycle got %0d required %0d", first_hs_cyc, rel + N - 1);
      end
      wait_drain();
   endtask

   task automatic test_reset_mid_drain();
      int s;
      send_frame(0, 1'b1, N, 1'b0, s);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (exp_q.size() <= 5) break;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b required 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready got %b required 1", in_ready); end
      @(posedge clk); #1;
      send_frame(8, 1'b1, N, 1'b0, s);
      wait_drain();
   endtask

   task automatic test_cfg_toggle();
      int s;
      send_frame(200, 1'b1, 3, 1'b0, s);
      wait_drain();
      send_frame(208, 1'b0, 2, 1'b0, s);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_bitrev_order();
      test_natural_order();
      test_back_to_back();
      test_stall();
      test_reset_mid_drain();
      test_cfg_toggle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout time=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
